matrix_scan_ctrl: RTL and testbench

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

---
 rtl/matrix_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl.sv
// HUB75-style LED matrix scan controller: shift, blank, latch, display per row pair.
// Define MATRIX_DOUBLE_BUFFER_EN to enable frame-boundary bank swapping.
module matrix_scan_ctrl #(
    parameter int COLS        = 32,
    parameter int ROWS        = 16,
    parameter int DISP_CYCLES = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       swap_req,
    output logic [9:0] fb_addr,
    input  logic [2:0] fb_data1,
    input  logic [2:0] fb_data2,
    output logic [2:0] RGB1,
    output logic [2:0] RGB2,
    output logic       sclk,
    output logic [3:0] rowD,
    output logic       LAT,
    output logic       OE,
    output logic       frame_done,
    output logic       swap_ack
);

    localparam int SW = $clog2(2*COLS+1);
    localparam int DW = $clog2(DISP_CYCLES);

    localparam logic [SW-1:0] STEP_LAST = SW'(2*COLS);
    localparam logic [DW-1:0] DISP_LAST = DW'(DISP_CYCLES-1);
    localparam logic [4:0]    COL_LAST  = 5'(COLS-1);
    localparam logic [3:0]    ROW_LAST  = 4'(ROWS-1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_BLANK   = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_DISPLAY = 3'd4;

    logic [2:0]    state, state_nx;
    logic [SW-1:0] step;
    logic [DW-1:0] dcnt;
    logic [4:0]    col;
    logic [3:0]    row;
    logic          bank;
    logic          shift_end, disp_end, frame_end;

    assign shift_end = (state == S_SHIFT) && (step == STEP_LAST);
    assign disp_end  = (state == S_DISPLAY) && (dcnt == DISP_LAST);
    assign frame_end = disp_end && (row == ROW_LAST);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (run) state_nx = S_SHIFT;
            S_SHIFT:   if (shift_end) state_nx = S_BLANK;
            S_BLANK:   state_nx = S_LATCH;
            S_LATCH:   state_nx = S_DISPLAY;
            S_DISPLAY: if (disp_end) state_nx = (frame_end && !run) ? S_IDLE : S_SHIFT;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            step  <= '0;
            dcnt  <= '0;
            col   <= '0;
            row   <= '0;
            RGB1  <= '0;
            RGB2  <= '0;
            rowD  <= '0;
            OE    <= 1'b1;
        end else begin
            state <= state_nx;
            step  <= (state == S_SHIFT && !shift_end) ? step + SW'(1) : '0;
            dcnt  <= (state == S_DISPLAY && !disp_end) ? dcnt + DW'(1) : '0;
            // Address leads the panel data by one read; park on the last column.
            if (state != S_SHIFT)
                col <= '0;
            else if (!step[0] && col != COL_LAST)
                col <= col + 5'd1;
            if (state == S_IDLE)
                row <= '0;
            else if (disp_end)
                row <= frame_end ? 4'd0 : row + 4'd1;
            if (state == S_SHIFT && step[0]) begin
                RGB1 <= fb_data1;
                RGB2 <= fb_data2;
            end
            if (shift_end)
                rowD <= row;
            // Previous row stays lit while the next one shifts in.
            if (state_nx == S_DISPLAY)
                OE <= 1'b0;
            else if (state_nx != S_SHIFT)
                OE <= 1'b1;
        end
    end

`ifdef MATRIX_DOUBLE_BUFFER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bank <= 1'b0;
        else if (frame_end && swap_req)
            bank <= ~bank;
    end
    assign swap_ack = frame_end && swap_req;
`else
    logic unused_swap;
    assign unused_swap = swap_req;
    assign bank        = 1'b0;
    assign swap_ack    = 1'b0;
`endif

    assign fb_addr    = {bank, row, col};
    assign sclk       = (state == S_SHIFT) && (step != '0) && !step[0];
    assign LAT        = (state == S_LATCH);
    assign frame_done = frame_end;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Scoreboard bench for matrix_scan_ctrl: panel capture, timing, run/swap/reset scenarios.
// Honours MATRIX_DOUBLE_BUFFER_EN to select the expected bank behaviour.
module tb_matrix_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       swap_req = 1'b0;
    logic [9:0] fb_addr;
    logic [2:0] fb_data1 = '0;
    logic [2:0] fb_data2 = '0;
    logic [2:0] RGB1, RGB2;
    logic       sclk, LAT, OE, frame_done, swap_ack;
    logic [3:0] rowD;

`ifdef MATRIX_DOUBLE_BUFFER_EN
    localparam logic DB = 1'b1;
`else
    localparam logic DB = 1'b0;
`endif

    typedef struct {
        logic [2:0] r1;
        logic [2:0] r2;
        logic [9:0] addr;
    } pix_t;

    pix_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   t0 = 0;
    logic sclk_d = 1'b0;
    logic chk_pix = 1'b0;

    matrix_scan_ctrl dut (
        .clk(clk), .reset(reset), .run(run), .swap_req(swap_req),
        .fb_addr(fb_addr), .fb_data1(fb_data1), .fb_data2(fb_data2),
        .RGB1(RGB1), .RGB2(RGB2), .sclk(sclk), .rowD(rowD),
        .LAT(LAT), .OE(OE), .frame_done(frame_done), .swap_ack(swap_ack)
    );

    always #5 clk = ~clk;

    // Synchronous frame buffer: pixel value is the column's low bits.
    always @(posedge clk) begin
        fb_data1 <= fb_addr[2:0];
        fb_data2 <= ~fb_addr[2:0];
    end

    task automatic push_row(input int r, input logic b);
        pix_t p;
        logic [4:0] cc, ac;
        for (int c = 0; c < 32; c++) begin
            cc = 5'(c);
            ac = (c == 31) ? 5'd31 : 5'(c + 1);
            p.r1 = cc[2:0];
            p.r2 = ~cc[2:0];
            p.addr = {b, 4'(r), ac};
            sb.push_back(p);
        end
    endtask

    // One clock; every panel sclk rise is popped against the scoreboard.
    task automatic tick();
        pix_t e;
        @(negedge clk);
        cyc++;
        if (sclk && !sclk_d && chk_pix) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL pixel_underflow: unexpected sclk rise at cycle %0d, want none", cyc);
            end else begin
                e = sb.pop_front();
                if ({RGB1, RGB2, fb_addr} !== {e.r1, e.r2, e.addr}) begin
                    miscompares++;
                    $display("FAIL pixel: got rgb1=%0d rgb2=%0d addr=%h, want rgb1=%0d rgb2=%0d addr=%h",
                             RGB1, RGB2, fb_addr, e.r1, e.r2, e.addr);
                end
            end
        end
        sclk_d = sclk;
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0; run = 1'b0; swap_req = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({OE, LAT, sclk} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_ctrl: got OE/LAT/sclk=%b, want 100", {OE, LAT, sclk});
        end
        vectors++;
        if ({RGB1, RGB2, rowD} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_data: got rgb1=%0d rgb2=%0d rowD=%0d, want 0", RGB1, RGB2, rowD);
        end
        vectors++;
        if ({fb_addr, frame_done, swap_ack} !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_addr: got addr=%h fd=%b ack=%b, want 0", fb_addr, frame_done, swap_ack);
        end
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sclk || !OE || LAT) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL idle_hold: got %0d active cycles with run=0, want 0", bad);
        end
    endtask

    task automatic test_first_row();
        int first_sclk, lat_at, lat_cnt, rises, oe_low, oe_shift_bad, rowd_bad, k;
        first_sclk = -1; lat_at = -1; lat_cnt = 0; rises = 0;
        oe_low = 0; oe_shift_bad = 0; rowd_bad = 0;
        reset = 1'b0; run = 1'b1;
        repeat (2) tick();
        sb.delete();
        for (int r = 0; r < 16; r++) push_row(r, 1'b0);
        chk_pix = 1'b1;
        reset = 1'b1;
        t0 = cyc;
        for (int n = 1; n <= 323; n++) begin
            tick();
            k = cyc - t0;
            if (sclk && first_sclk < 0) first_sclk = k;
            if (sclk && lat_at < 0) rises++;
            if (LAT) begin
                lat_cnt++;
                if (lat_at < 0) lat_at = k;
            end
            if (!OE) oe_low++;
            if (k <= 65 && !OE) oe_shift_bad++;
            if (!OE && rowD != 4'd0) rowd_bad++;
        end
        vectors++;
        if (first_sclk != 3) begin
            miscompares++;
            $display("FAIL first_sclk: got cycle %0d, want 3", first_sclk);
        end
        vectors++;
        if (rises != 32) begin
            miscompares++;
            $display("FAIL sclk_edges: got %0d, want 32", rises);
        end
        vectors++;
        if (lat_at != 67 || lat_cnt != 1) begin
            miscompares++;
            $display("FAIL latch: got at %0d count %0d, want at 67 count 1", lat_at, lat_cnt);
        end
        vectors++;
        if (oe_low != 256 || oe_shift_bad != 0) begin
            miscompares++;
            $display("FAIL oe_window: got low=%0d shift_low=%0d, want 256 and 0", oe_low, oe_shift_bad);
        end
        vectors++;
        if (rowd_bad != 0) begin
            miscompares++;
            $display("FAIL row0_select: got %0d lit cycles off row 0, want 0", rowd_bad);
        end
    endtask

    task automatic test_frame();
        int fd_at, fd_cnt, seq_bad;
        logic [3:0] lr[$];
        fd_at = -1; fd_cnt = 0; seq_bad = 0;
        for (int r = 0; r < 16; r++) push_row(r, 1'b0);
        while (cyc - t0 < 5170) begin
            tick();
            if (LAT) lr.push_back(rowD);
            if (frame_done) begin
                fd_cnt++;
                if (fd_at < 0) fd_at = cyc - t0;
            end
        end
        vectors++;
        if (fd_at != 5168 || fd_cnt != 1) begin
            miscompares++;
            $display("FAIL frame_done: got at %0d count %0d, want at 5168 count 1", fd_at, fd_cnt);
        end
        for (int i = 0; i < lr.size(); i++)
            if (lr[i] != 4'(i + 1)) seq_bad++;
        vectors++;
        if (lr.size() != 15 || seq_bad != 0) begin
            miscompares++;
            $display("FAIL row_seq: got %0d latches %0d misordered, want 15 and 0", lr.size(), seq_bad);
        end
        for (int i = 0; i < 400; i++) begin
            tick();
            if (LAT) break;
        end
        vectors++;
        if (!LAT || rowD !== 4'd0) begin
            miscompares++;
            $display("FAIL row_wrap: got LAT=%b rowD=%0d, want 1 and 0", LAT, rowD);
        end
    endtask

    task automatic test_run_drop();
        int lat_n, fd_at, bad;
        logic [3:0] last_row;
        lat_n = 0; fd_at = -1; bad = 0; last_row = '0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (LAT && rowD == 4'd7) break;
        end
        run = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (LAT) begin
                lat_n++;
                last_row = rowD;
            end
            if (frame_done) begin
                fd_at = cyc - t0;
                break;
            end
        end
        vectors++;
        if (lat_n != 8 || last_row != 4'd15 || fd_at != 10336) begin
            miscompares++;
            $display("FAIL run_drop: got %0d rows last=%0d end=%0d, want 8 rows last=15 end=10336",
                     lat_n, last_row, fd_at);
        end
        for (int i = 0; i < 500; i++) begin
            tick();
            if (sclk || !OE || LAT) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL idle_after_drop: got %0d active cycles, want 0", bad);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL pixel_count: got %0d unshifted pixels, want 0", sb.size());
        end
        chk_pix = 1'b0;
    endtask

    task automatic test_swap();
        int stray, bank_bad, acks;
        logic ack_fd, seen;
        stray = 0; bank_bad = 0; acks = 0; ack_fd = 1'bx; seen = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (LAT && rowD == 4'd3) break;
        end
        swap_req = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (swap_ack && !frame_done) stray++;
            if (fb_addr[9]) bank_bad++;
            if (frame_done) begin
                ack_fd = swap_ack;
                break;
            end
        end
        swap_req = 1'b0;
        vectors++;
        if (stray != 0 || bank_bad != 0) begin
            miscompares++;
            $display("FAIL swap_midframe: got %0d stray acks %0d early bank, want 0 and 0", stray, bank_bad);
        end
        vectors++;
        if (ack_fd !== DB) begin
            miscompares++;
            $display("FAIL swap_ack: got %b at frame end, want %b", ack_fd, DB);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sclk) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen || fb_addr[9] !== DB) begin
            miscompares++;
            $display("FAIL new_bank: got sclk=%b addr[9]=%b, want 1 and %b", seen, fb_addr[9], DB);
        end
        bank_bad = 0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (swap_ack) acks++;
            if (fb_addr[9] !== DB) bank_bad++;
            if (frame_done) break;
        end
        vectors++;
        if (acks != 0 || bank_bad != 0) begin
            miscompares++;
            $display("FAIL bank_stable: got %0d acks %0d bank flips, want 0 and 0", acks, bank_bad);
        end
    endtask

    task automatic test_reset_mid();
        int rises, lat_at, bad;
        rises = 0; lat_at = -1; bad = 0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (LAT && rowD == 4'd1) break;
        end
        for (int i = 0; i < 700; i++) begin
            tick();
            if (sclk) rises++;
            if (rises == 17) break;
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({OE, LAT, sclk} !== 3'b100 || fb_addr !== 10'd0) begin
            miscompares++;
            $display("FAIL async_ctrl: got OE/LAT/sclk=%b addr=%h, want 100 and 000", {OE, LAT, sclk}, fb_addr);
        end
        vectors++;
        if ({RGB1, RGB2, rowD} !== 10'd0) begin
            miscompares++;
            $display("FAIL async_data: got rgb1=%0d rgb2=%0d rowD=%0d, want 0", RGB1, RGB2, rowD);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (sclk || !OE) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL held_reset: got %0d active cycles, want 0", bad);
        end
        sb.delete();
        push_row(0, 1'b0);
        chk_pix = 1'b1;
        reset = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (LAT) begin
                lat_at = cyc - t0;
                break;
            end
        end
        chk_pix = 1'b0;
        vectors++;
        if (lat_at != 67 || rowD !== 4'd0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL restart: got latch %0d rowD=%0d left=%0d, want 67 0 0", lat_at, rowD, sb.size());
        end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_row();
        test_frame();
        test_run_drop();
        test_swap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
